// File: rtl/ram_rw_arb_rr.sv
// Single-port RAM access arbiter: round-robin or fixed-priority grant across NUM_PORTS
// requesters, with burst locking and a forced release when a lock owner stalls.
module ram_rw_arb_rr #(
    parameter int NUM_PORTS    = 4,
    parameter int ARB_MODE     = 0,
    parameter int LOCK_TIMEOUT = 16,
    parameter int PTR_W        = $clog2(NUM_PORTS)
) (
    input  logic                 aclk_s,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] req_wr,
    input  logic [NUM_PORTS-1:0] wdata_ready,
    input  logic [NUM_PORTS-1:0] req_last,
    output logic [NUM_PORTS-1:0] ack,
    output logic [PTR_W-1:0]     ack_id,
    output logic                 locked,
    output logic [PTR_W-1:0]     lock_owner,
    output logic                 lock_timeout
);

    localparam logic [0:0]       ST_UNLOCKED = 1'b0;
    localparam logic [0:0]       ST_LOCKED   = 1'b1;
    localparam int               SUM_W       = PTR_W + 1;
    localparam logic [7:0]       TIMEOUT_CNT = 8'(LOCK_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_PORTS - 1);

    logic [0:0]           state_q, state_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]           idle_cnt_q, idle_cnt_d;
    logic                 pulse_q, pulse_d;

    logic [NUM_PORTS-1:0] eligible;
    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [SUM_W-1:0]     cand_sum;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    assign eligible = req & (~req_wr | wdata_ready);

    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        if (state_q == ST_LOCKED) begin
            // The timeout cycle withholds the owner's grant so the release is clean.
            if (eligible[owner_q] && idle_cnt_q != TIMEOUT_CNT) begin
                grant_valid = 1'b1;
                grant_idx   = owner_q;
            end
        end else if (ARB_MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = PTR_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                cand_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
                if (cand_sum >= SUM_W'(NUM_PORTS)) begin
                    cand_sum = cand_sum - SUM_W'(NUM_PORTS);
                end
                if (!grant_valid && eligible[cand_sum[PTR_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_sum[PTR_W-1:0];
                end
            end
        end
        if (rst) begin
            grant_valid = 1'b0;
            grant_idx   = '0;
        end
    end

    assign ack    = grant_valid ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign ack_id = grant_idx;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        pulse_d    = 1'b0;
        if (state_q == ST_UNLOCKED) begin
            if (grant_valid) begin
                if (req_last[grant_idx]) begin
                    rr_ptr_d = next_idx(grant_idx);
                end else begin
                    state_d    = ST_LOCKED;
                    owner_d    = grant_idx;
                    idle_cnt_d = '0;
                end
            end
        end else if (grant_valid) begin
            idle_cnt_d = '0;
            if (req_last[grant_idx]) begin
                state_d  = ST_UNLOCKED;
                rr_ptr_d = next_idx(grant_idx);
            end
        end else if (idle_cnt_q == TIMEOUT_CNT) begin
            state_d    = ST_UNLOCKED;
            idle_cnt_d = '0;
            rr_ptr_d   = next_idx(owner_q);
        end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
            pulse_d    = (idle_cnt_q == TIMEOUT_CNT - 8'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk_s) begin
        if (rst) begin
            state_q    <= ST_UNLOCKED;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    assign locked       = (state_q == ST_LOCKED);
    assign lock_owner   = owner_q;
    assign lock_timeout = pulse_q;

endmodule

// File: tb/tb_ram_rw_arb_rr.sv
// Directed bench for ram_rw_arb_rr: a round-robin and a fixed-priority instance share stimulus,
// both checked every cycle against a behavioural model plus hand-computed literal expectations.
module tb_ram_rw_arb_rr;

    localparam int N  = 4;
    localparam int LT = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req, req_wr, wdata_ready, req_last;

    logic [N-1:0] ack_rr, ack_fp;
    logic [1:0]   id_rr, id_fp, owner_rr, owner_fp;
    logic         locked_rr, locked_fp, tmo_rr, tmo_fp;

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    int m_locked [2];
    int m_owner  [2];
    int m_idle   [2];
    int m_ptr    [2];
    int m_pulse  [2];

    ram_rw_arb_rr #(.NUM_PORTS(N), .ARB_MODE(0), .LOCK_TIMEOUT(LT)) dut_rr (
        .aclk_s(clk), .rst(rst), .req(req), .req_wr(req_wr),
        .wdata_ready(wdata_ready), .req_last(req_last), .ack(ack_rr), .ack_id(id_rr),
        .locked(locked_rr), .lock_owner(owner_rr), .lock_timeout(tmo_rr)
    );

    ram_rw_arb_rr #(.NUM_PORTS(N), .ARB_MODE(1), .LOCK_TIMEOUT(LT)) dut_fp (
        .aclk_s(clk), .rst(rst), .req(req), .req_wr(req_wr),
        .wdata_ready(wdata_ready), .req_last(req_last), .ack(ack_fp), .ack_id(id_fp),
        .locked(locked_fp), .lock_owner(owner_fp), .lock_timeout(tmo_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Port that must be granted this cycle, or -1 for none.
    function automatic int model_grant(input int d, input logic [N-1:0] elig, input logic r);
        if (r) return -1;
        if (m_locked[d] != 0)
            return (elig[m_owner[d]] && m_idle[d] < LT) ? m_owner[d] : -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (d == 1) ? k : (m_ptr[d] + k) % N;
            if (elig[p]) return p;
        end
        return -1;
    endfunction

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_locked[d] = 0; m_owner[d] = 0; m_idle[d] = 0; m_ptr[d] = 0; m_pulse[d] = 0;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] elig;
        elig = req & (~req_wr | wdata_ready);
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [N-1:0] exp_ack;
            g = model_grant(d, elig, rst);
            exp_ack = (g >= 0) ? N'(1) << g : '0;
            if (d == 0) begin
                check("rr_ack", ack_rr, exp_ack);
                if (g >= 0) check("rr_ack_id", id_rr, g);
                check("rr_locked", locked_rr, m_locked[d]);
                check("rr_owner", owner_rr, m_owner[d]);
                check("rr_timeout", tmo_rr, m_pulse[d]);
            end else begin
                check("fp_ack", ack_fp, exp_ack);
                if (g >= 0) check("fp_ack_id", id_fp, g);
                check("fp_locked", locked_fp, m_locked[d]);
                check("fp_owner", owner_fp, m_owner[d]);
                check("fp_timeout", tmo_fp, m_pulse[d]);
            end
            m_pulse[d] = 0;
            if (rst) begin
                m_locked[d] = 0; m_owner[d] = 0; m_idle[d] = 0; m_ptr[d] = 0;
            end else if (g >= 0) begin
                m_idle[d] = 0;
                if (req_last[g]) begin
                    m_locked[d] = 0;
                    m_ptr[d] = (g + 1) % N;
                end else begin
                    m_locked[d] = 1;
                    m_owner[d] = g;
                end
            end else if (m_locked[d] != 0) begin
                if (m_idle[d] == LT) begin
                    m_locked[d] = 0;
                    m_idle[d] = 0;
                    m_ptr[d] = (m_owner[d] + 1) % N;
                end else begin
                    m_idle[d]++;
                    m_pulse[d] = (m_idle[d] == LT) ? 1 : 0;
                end
            end
        end
    end

    // Applies one cycle of inputs just after the edge, then waits until outputs are settled mid-cycle.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] wr,
                        input logic [N-1:0] wd, input logic [N-1:0] lst);
        @(posedge clk);
        #1;
        rst = r; req = rq; req_wr = wr; wdata_ready = wd; req_last = lst;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] fair_seq [5];
        fair_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req = 4'b1111; req_wr = '0; wdata_ready = '0; req_last = 4'b1111;

        step(1, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        check("reset_ack_rr", ack_rr, 4'b0000);
        check("reset_ack_fp", ack_fp, 4'b0000);
        check("reset_locked", locked_rr, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
            check("rr_fairness", ack_rr, fair_seq[i]);
            check("fp_lowest", ack_fp, 4'b0001);
        end

        step(0, 4'b0110, 4'b0010, 4'b0000, 4'b1111);
        check("write_gated", ack_rr, 4'b0100);
        step(0, 4'b0010, 4'b0010, 4'b0010, 4'b1111);
        check("write_ready", ack_rr, 4'b0010);
        check("write_ready_id", id_rr, 2'd1);

        step(0, 4'b0101, 4'b0000, 4'b0000, 4'b0001);
        check("burst_b1_ack", ack_rr, 4'b0100);
        check("burst_b1_locked", locked_rr, 1'b0);
        step(0, 4'b0101, 4'b0000, 4'b0000, 4'b0001);
        check("burst_b2_ack", ack_rr, 4'b0100);
        check("burst_b2_locked", locked_rr, 1'b1);
        check("burst_b2_owner", owner_rr, 2'd2);
        step(0, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
        check("burst_b3_ack", ack_rr, 4'b0100);
        check("burst_b3_locked", locked_rr, 1'b1);
        step(0, 4'b0001, 4'b0000, 4'b0000, 4'b1111);
        check("burst_after_ack", ack_rr, 4'b0001);
        check("burst_after_locked", locked_rr, 1'b0);

        step(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        check("tmo_grab", ack_rr, 4'b1000);
        for (int i = 0; i < LT; i++) begin
            step(0, 4'b0010, 4'b0000, 4'b0000, 4'b1111);
            check("tmo_wait_ack", ack_rr, 4'b0000);
            check("tmo_wait_pulse", tmo_rr, 1'b0);
        end
        step(0, 4'b0010, 4'b0000, 4'b0000, 4'b1111);
        check("tmo_pulse_ack", ack_rr, 4'b0000);
        check("tmo_pulse", tmo_rr, 1'b1);
        check("tmo_pulse_fp", tmo_fp, 1'b1);
        step(0, 4'b1010, 4'b0000, 4'b0000, 4'b1111);
        check("tmo_release_ack", ack_rr, 4'b0010);
        check("tmo_release_pulse", tmo_rr, 1'b0);
        check("tmo_release_locked", locked_rr, 1'b0);

        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1010, 4'b0000, 4'b0000, 4'b1111);
            check("fixed_prio", ack_fp, 4'b0010);
        end

        step(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        check("rstb_grab", ack_rr, 4'b0100);
        step(0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
        check("rstb_locked", locked_rr, 1'b1);
        step(1, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
        check("rstb_ack_in_reset", ack_rr, 4'b0000);
        step(0, 4'b0110, 4'b0000, 4'b0000, 4'b1111);
        check("rstb_unlocked", locked_rr, 1'b0);
        check("rstb_owner", owner_rr, 2'd0);
        check("rstb_lowest", ack_rr, 4'b0010);

        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
